// File: rtl/ctrl_pkg.sv
// ctrl_pkg: control-bundle type, ALUOp encodings and the bubble constant shared by the control pipeline
package ctrl_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg;
  } ctrl_t;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/ctrl_pipe_hazard_detect.sv
// hazard_detect: combinational load-use hazard, IF/ID stall and wrong-path flush
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              id_alu_src,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  output logic              hz,
  output logic              stall,
  output logic              flush
);
  logic uses_rs2;
  // A load in EX whose result the ID instruction reads forces one bubble; x0 never counts.
  // A taken branch squashes the ID instruction, so a flush overrides the stall request.
  always_comb begin
    uses_rs2 = ~id_alu_src | id_mem_write;
    hz       = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
               ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2)));
    flush    = ex_branch_taken & ex_valid;
    stall    = hz & ~flush;
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control through ID/EX, EX/MEM, MEM/WB with load-use stall, branch flush and stall counter
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic [1:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic [1:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic [CNT_W-1:0]  stall_count
);
  ctrl_t id_c, ex_c;
  logic  hz;

  assign id_c = '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                  branch: id_branch, alu_src: id_alu_src, alu_op: id_alu_op,
                  mem_to_reg: id_mem_to_reg};

  hazard_detect #(.REG_AW(REG_AW)) u_hz (
    .id_valid        (id_valid),
    .id_alu_src      (id_alu_src),
    .id_mem_write    (id_mem_write),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .hz              (hz),
    .stall           (stall_if_id),
    .flush           (flush_if_id)
  );

  // ID->EX: bubble on hazard or flush, otherwise take the decoder bundle with invalid slots zeroed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_c     <= CTRL_NOP;
      ex_rd    <= '0;
    end else if (hz || flush_if_id) begin
      ex_valid <= 1'b0;
      ex_c     <= CTRL_NOP;
      ex_rd    <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_c     <= id_valid ? id_c : CTRL_NOP;
      ex_rd    <= id_rd;
    end
  end

  assign ex_reg_write  = ex_c.reg_write;
  assign ex_mem_read   = ex_c.mem_read;
  assign ex_mem_write  = ex_c.mem_write;
  assign ex_branch     = ex_c.branch;
  assign ex_alu_src    = ex_c.alu_src;
  assign ex_alu_op     = ex_c.alu_op;
  assign ex_mem_to_reg = ex_c.mem_to_reg;

  // EX->MEM and MEM->WB: free-running advance, no back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_rd         <= '0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_rd          <= '0;
    end else begin
      mem_valid      <= ex_valid;
      mem_reg_write  <= ex_c.reg_write;
      mem_mem_read   <= ex_c.mem_read;
      mem_mem_write  <= ex_c.mem_write;
      mem_mem_to_reg <= ex_c.mem_to_reg;
      mem_rd         <= ex_rd;
      wb_valid       <= mem_valid;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_rd          <= mem_rd;
    end
  end

  // Stall-cycle counter that sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (stall_if_id && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe covering flow, load-use, flush, reset and counter saturation
module tb_ctrl_pipe;
  import ctrl_pkg::*;
  localparam int CW = 3;
  localparam int AW = 5;

  typedef struct packed {
    logic          v;
    ctrl_t         c;
    logic [AW-1:0] rs1, rs2, rd;
  } id_t;
  typedef struct packed {
    logic          v;
    ctrl_t         c;
    logic [AW-1:0] rd;
  } st_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src, id_mem_to_reg;
  logic [1:0] id_alu_op, ex_alu_op;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd;
  logic ex_branch_taken;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_mem_to_reg;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic wb_valid, wb_reg_write, wb_mem_to_reg;
  logic stall_if_id, flush_if_id;
  logic [CW-1:0] stall_count;

  int n_tests = 0, n_fail = 0;
  string tname = "init";
  st_t q[$];
  int cnt;

  always #5 clk = ~clk;

  ctrl_pipe #(.CNT_W(CW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_alu_src(id_alu_src),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", tname, tag, got, exp);
    end
  endtask

  function automatic id_t mk(input logic rw, mr, mw, br, as, input logic [1:0] op, input logic m2r,
                             input int rs1, rs2, rd);
    mk = '{v: 1'b1, c: '{rw, mr, mw, br, as, op, m2r}, rs1: AW'(rs1), rs2: AW'(rs2), rd: AW'(rd)};
  endfunction
  function automatic id_t r_type(input int rd, rs1, rs2); return mk(1,0,0,0,0,ALUOP_FUNCT,0,rs1,rs2,rd); endfunction
  function automatic id_t lw(input int rd, rs1);          return mk(1,1,0,0,1,ALUOP_ADD,1,rs1,0,rd);   endfunction
  function automatic id_t sw(input int rs1, rs2);         return mk(0,0,1,0,1,ALUOP_ADD,0,rs1,rs2,0);  endfunction
  function automatic id_t beq(input int rs1, rs2);        return mk(0,0,0,1,0,ALUOP_BR,0,rs1,rs2,0);   endfunction
  function automatic id_t addi(input int rd, rs1, imm);   return mk(1,0,0,0,1,ALUOP_ADD,0,rs1,imm,rd); endfunction
  function automatic id_t nop();                          return '0;                                   endfunction

  task automatic drive(input id_t i, input logic tk);
    {id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src, id_alu_op, id_mem_to_reg} = i.c;
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; ex_branch_taken = tk;
  endtask

  // One cycle: check combinational stall/flush, predict the new EX entry, then compare every stage after the edge
  task automatic step(input id_t i, input logic tk, input logic es, input logic ef);
    st_t ne, w;
    drive(i, tk);
    #1;
    chk("stall", stall_if_id, es);
    chk("flush", flush_if_id, ef);
    ne = (es || ef) ? '0 : '{v: i.v, c: i.v ? i.c : CTRL_NOP, rd: i.rd};
    if (es && cnt != 7) cnt++;
    @(posedge clk); #1;
    q.push_back(ne);
    w = q.pop_front();
    chk("ex", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_alu_op, ex_mem_to_reg, ex_rd},
        {q[1].v, q[1].c, q[1].rd});
    chk("mem", {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_rd},
        {q[0].v, q[0].c.reg_write, q[0].c.mem_read, q[0].c.mem_write, q[0].c.mem_to_reg, q[0].rd});
    chk("wb", {wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd}, {w.v, w.c.reg_write, w.c.mem_to_reg, w.rd});
    chk("cnt", 32'(stall_count), cnt);
  endtask

  task automatic do_reset();
    drive(nop(), 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    q = {st_t'('0), st_t'('0)};
    cnt = 0;
    #1;
  endtask

  task automatic flush_out();
    for (int k = 0; k < 3; k++) step(nop(), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(nop(), 1'b0);
    #1;
    tname = "reset";
    chk("por", {ex_valid, mem_valid, wb_valid, stall_if_id, flush_if_id, 32'(stall_count)}, 0);
    do_reset();

    tname = "t1_async_reset";
    step(r_type(5, 1, 2), 1'b0, 1'b0, 1'b0);
    step(lw(6, 1), 1'b0, 1'b0, 1'b0);
    step(r_type(9, 6, 2), 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ex_clr", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_to_reg, ex_alu_op, ex_rd}, 0);
    chk("mem_clr", {mem_valid, mem_reg_write, mem_mem_read, mem_rd}, 0);
    chk("wb_clr", {wb_valid, wb_reg_write, wb_rd}, 0);
    chk("comb_clr", {stall_if_id, flush_if_id}, 0);
    chk("cnt_clr", 32'(stall_count), 0);
    do_reset();
    tname = "t1_alu_flow";
    step(r_type(5, 1, 2), 1'b0, 1'b0, 1'b0);
    chk("ex_rw", {ex_reg_write, ex_alu_op}, 3'b110);
    step(nop(), 1'b0, 1'b0, 1'b0);
    chk("mem_rd", 32'(mem_rd), 5);
    step(nop(), 1'b0, 1'b0, 1'b0);
    chk("wb", {wb_reg_write, wb_rd}, {1'b1, 5'd5});
    step(nop(), 1'b0, 1'b0, 1'b0);

    tname = "t2_load_use_rs1";
    do_reset();
    step(lw(7, 1), 1'b0, 1'b0, 1'b0);
    step(r_type(8, 7, 3), 1'b0, 1'b1, 1'b0);
    chk("bubble", ex_valid, 1'b0);
    step(r_type(8, 7, 3), 1'b0, 1'b0, 1'b0);
    chk("add_in_ex", {ex_valid, ex_rd}, {1'b1, 5'd8});
    chk("cnt1", 32'(stall_count), 1);
    flush_out();

    tname = "t3_no_false_stall";
    do_reset();
    step(lw(7, 1), 1'b0, 1'b0, 1'b0);
    step(addi(9, 4, 7), 1'b0, 1'b0, 1'b0);
    step(lw(0, 1), 1'b0, 1'b0, 1'b0);
    step(r_type(1, 0, 0), 1'b0, 1'b0, 1'b0);
    flush_out();

    tname = "t4_branch_flush";
    do_reset();
    step(beq(1, 2), 1'b0, 1'b0, 1'b0);
    step(r_type(5, 1, 2), 1'b1, 1'b0, 1'b1);
    chk("ex_squash", ex_valid, 1'b0);
    chk("mem_beq", {mem_valid, mem_reg_write}, 2'b10);
    flush_out();

    tname = "t5_hazard_and_flush";
    do_reset();
    step(lw(2, 1), 1'b0, 1'b0, 1'b0);
    step(sw(3, 2), 1'b1, 1'b0, 1'b1);
    chk("cnt0", 32'(stall_count), 0);
    flush_out();

    tname = "t6_saturate";
    do_reset();
    step(lw(1, 0), 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(lw(k + 1, k), 1'b0, 1'b1, 1'b0);
      step(lw(k + 1, k), 1'b0, 1'b0, 1'b0);
    end
    chk("cnt_sat", 32'(stall_count), 7);
    flush_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
